uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART byte receiver for the serial-link blocks, replacing the fixed 8N1 receiver. Runtime baud divisor, configurable data width, optional even/odd parity, one or two stop bits, and three-sample majority voting per bit. Reports parity and framing errors alongside the received word. Sits between the board RX pin and the command parser / RX FIFO, in the single system clock domain.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, sampling ticks per bit, even, legal 8..32
- DIV_W, 16, width of baud_div

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  reset; synchronous, active-low
- uart_rx  in  1  asynchronous serial line, idle high
- baud_div  in  DIV_W  Clk cycles per sampling tick minus 1
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 none
- stop_bits  in  1  0 one stop bit, 1 two stop bits
- Data  out  DATA_BITS  last received word, LSB first on the line
- Rx_Done  out  1  one-cycle pulse, Data and error flags valid
- parity_err  out  1  parity mismatch for the frame in Data
- frame_err  out  1  a stop bit sampled low for the frame in Data
- busy  out  1  high from start detection until return to IDLE

## Operation
- uart_rx passes through a 2-FF synchroniser; a falling edge is detected on the synchronised value (previous 1, current 0).
- Configuration latch: baud_div, parity_mode and stop_bits are captured at start detection and held for the whole frame.
- Tick generator: div_cnt runs 0..baud_div_latched and wraps; tick = (div_cnt == baud_div_latched). It is held at 0 in IDLE and cleared at start detection.
- Bit timing: tick_cnt 0..OVERSAMPLE-1 within each bit. Samples are taken on ticks M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 samples.
- FSM states:
  - IDLE -> START on falling edge.
  - START -> IDLE if majority is 1 (glitch rejected, no Rx_Done); otherwise -> DATA at bit end.
  - DATA collects DATA_BITS bits LSB first, then -> PARITY if parity enabled, else -> STOP.
  - PARITY: even requires XOR(data, parity bit) = 0; odd requires it = 1.
  - STOP runs 1 or 2 stop bits. frame_err is set if any stop majority is 0.
  - After the last stop bit's M+1 sample -> DONE, and DONE -> IDLE after one cycle. Returning at mid-stop lets back-to-back frames be caught.
- In DONE: Rx_Done = 1; Data, parity_err and frame_err are loaded. All three hold until the next DONE.
- Break or stuck-low line: the frame completes with frame_err = 1. No new start is accepted until the synchronised line has been seen high (edge rule).
- busy = (state != IDLE).

## Timing
- Reset (Reset_n low at a Clk edge): state IDLE, Data = 0, Rx_Done = 0, parity_err = 0, frame_err = 0, busy = 0, all counters 0. Reset mid-frame aborts the frame with no Rx_Done.
- Start detection takes 3 Clk after the pin falls (2 sync + edge register); busy rises on that edge.
- One bit period = (baud_div + 1) * OVERSAMPLE Clk.
- Rx_Done fires 1 Clk after the tick carrying the final stop bit's M+1 sample, and is exactly one cycle wide.
- Data is stable from the Rx_Done cycle onward. Consumers sample Data on the Rx_Done cycle.
- Minimum accepted start pulse is 2 ticks low around the mid-bit; shorter pulses are rejected.
- baud_div = 0 is legal: a tick every Clk.

## Test plan
- 8N1 at baud_div = 3 (64 Clk per bit), frame 0xA5 -> Data = 0xA5, Rx_Done single pulse, both error flags 0. Rx_Done lands 3 + 9*64 + (M+1)*4 + 1 Clk after the falling edge (OVERSAMPLE = 16, M = 8).
- 8E1, parity_mode = 1, 0x03 sent with parity bit 1 -> Data = 0x03, parity_err = 1. Resend with parity bit 0 -> parity_err = 0. Repeat with odd parity (parity_mode = 2) and the inverse expectations.
- 8N2, stop_bits = 1, 0x5A with second stop bit driven low -> frame_err = 1, Data = 0x5A. Line held low 20 bit times -> frame_err = 1, Data = 0x00, then no further Rx_Done until the line goes high and falls again.
- Start glitch 1 tick long -> busy pulses then falls, no Rx_Done. A single-tick glitch inside data bit 3 of 0xFF -> Data still 0xFF (majority vote).
- Back-to-back 0x11, 0x22 with one stop bit and no idle gap -> two Rx_Done pulses, Data = 0x11 then 0x22. Also cover DATA_BITS = 7 instance: 0x7F -> Data = 7'h7F.
- Reset_n driven low during data bit 4 -> all outputs 0 on the next edge. Next clean frame 0xC3 -> received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART byte receiver: runtime baud divisor, 5..9 data bits, optional parity,
// one or two stop bits, 3-sample majority voting, parity/framing error reporting.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 uart_rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Rx_Done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int M      = OVERSAMPLE / 2;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = 4;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SMP_A     = TICK_W'(M - 1);
  localparam logic [TICK_W-1:0] SMP_B     = TICK_W'(M);
  localparam logic [TICK_W-1:0] SMP_C     = TICK_W'(M + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]     div_lat_q, div_lat_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 frame_acc_q, frame_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  logic                 fall;
  logic                 active;
  logic                 tick;
  logic [TICK_W-1:0]    tick_nxt;
  logic                 bit_end;
  logic                 smp_c;
  logic                 maj;
  logic                 par_en;

  // Sync flops reset to the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      div_lat_q    <= '0;
      pmode_q      <= '0;
      stop2_q      <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      stop_idx_q   <= 1'b0;
      smp_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      frame_acc_q  <= 1'b0;
      data_q       <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      div_lat_q    <= div_lat_d;
      pmode_q      <= pmode_d;
      stop2_q      <= stop2_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_idx_q   <= stop_idx_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      frame_acc_q  <= frame_acc_d;
      data_q       <= data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    fall     = rx_prev_q & ~rx_sync_q;
    active   = (state_q == S_START) || (state_q == S_DATA) ||
               (state_q == S_PARITY) || (state_q == S_STOP);
    tick     = active && (div_cnt_q == div_lat_q);
    tick_nxt = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
    bit_end  = tick && (tick_cnt_q == TICK_LAST);
    // Samples land on the ticks that advance tick_cnt to M-1, M and M+1.
    smp_c    = tick && (tick_nxt == SMP_C);
    maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
    par_en   = (pmode_q == 2'd1) || (pmode_q == 2'd2);

    state_d      = state_q;
    div_cnt_d    = '0;
    div_lat_d    = div_lat_q;
    pmode_d      = pmode_q;
    stop2_d      = stop2_q;
    tick_cnt_d   = '0;
    bit_cnt_d    = bit_cnt_q;
    stop_idx_d   = stop_idx_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    frame_acc_d  = frame_acc_q;
    data_d       = data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (active) begin
      div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
      tick_cnt_d = tick ? tick_nxt : tick_cnt_q;
      if (tick && (tick_nxt == SMP_A)) smp_d[0] = rx_sync_q;
      if (tick && (tick_nxt == SMP_B)) smp_d[1] = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d     = S_START;
          div_lat_d   = baud_div;
          pmode_d     = parity_mode;
          stop2_d     = stop_bits;
          bit_cnt_d   = '0;
          stop_idx_d  = 1'b0;
          smp_d       = '0;
          frame_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (smp_c && maj) state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (smp_c) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) state_d = par_en ? S_PARITY : S_STOP;
          else bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_PARITY: begin
        if (smp_c) par_bit_d = maj;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (smp_c) begin
          if (!maj) frame_acc_d = 1'b1;
          // Leave at mid-stop so a start bit right after the stop bit is still caught.
          if (stop_idx_q == stop2_q) state_d = S_DONE;
        end
        if (bit_end) stop_idx_d = 1'b1;
      end
      S_DONE: begin
        state_d      = S_IDLE;
        rx_done_d    = 1'b1;
        data_d       = shift_q;
        parity_err_d = par_en && ((^shift_q ^ par_bit_q) != (pmode_q == 2'd2));
        frame_err_d  = frame_acc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Data       = data_q;
  assign Rx_Done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit instance for most scenarios plus a 7-bit instance.
module tb_uart_rx_param;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        uart_rx;
  logic        uart_rx7;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop_bits;

  logic [7:0]  Data;
  logic        Rx_Done, parity_err, frame_err, busy;
  logic [6:0]  Data7;
  logic        Rx_Done7, parity_err7, frame_err7, busy7;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int done7_cnt = 0;
  int wide_cnt = 0;
  logic done_prev = 1'b0;
  logic busy_seen = 1'b0;
  logic [7:0] data_log [0:31];
  logic [7:0] last_data;
  logic       last_perr, last_ferr;
  logic [6:0] last_data7;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .uart_rx(uart_rx), .baud_div(baud_div),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .Data(Data), .Rx_Done(Rx_Done),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .DIV_W(16)) u_dut7 (
    .Clk(Clk), .Reset_n(Reset_n), .uart_rx(uart_rx7), .baud_div(baud_div),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .Data(Data7), .Rx_Done(Rx_Done7),
    .parity_err(parity_err7), .frame_err(frame_err7), .busy(busy7)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Rx_Done) begin
      if (done_prev) wide_cnt++;
      data_log[done_cnt % 32] = Data;
      last_data = Data;
      last_perr = parity_err;
      last_ferr = frame_err;
      done_cyc  = cyc;
      done_cnt++;
    end
    done_prev = Rx_Done;
    if (Rx_Done7) begin
      last_data7 = Data7;
      done7_cnt++;
    end
    if (busy) busy_seen = 1'b1;
  end

  // Bit 0 is the start bit; unused upper bits stay 1 (stop/idle).
  function automatic logic [31:0] frame(input logic [8:0] d, input int nd, input int pbit);
    logic [31:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[i+1] = d[i];
    if (pbit >= 0) f[nd+1] = pbit[0];
    return f;
  endfunction

  // Drives nbits bit periods; clocks g_lo..g_hi are inverted; cut > 0 stops early and leaves the line.
  task automatic drive(input int sel, input logic [31:0] bits, input int nbits,
                       input int g_lo, input int g_hi, input int cut);
    int p;
    int lim;
    logic v;
    p = (int'(baud_div) + 1) * 16;
    lim = (cut > 0) ? cut : nbits * p;
    for (int c = 0; c < lim; c++) begin
      @(posedge Clk); #1;
      if (c == 0) start_cyc = cyc;
      v = bits[c / p];
      if (c >= g_lo && c <= g_hi) v = ~v;
      if (sel == 0) uart_rx = v; else uart_rx7 = v;
    end
    if (cut == 0) begin
      @(posedge Clk); #1;
      if (sel == 0) uart_rx = 1'b1; else uart_rx7 = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; uart_rx = 1'b1; uart_rx7 = 1'b1;
    baud_div = 16'd3; parity_mode = 2'd0; stop_bits = 1'b0;
    idle(3);
    n_total++; if (Data !== 8'h00) $display("FAIL reset_data: got %h want 00", Data); else n_pass++;
    n_total++; if (Rx_Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Rx_Done); else n_pass++;
    n_total++; if ({parity_err, frame_err} !== 2'b00) $display("FAIL reset_errs: got %b want 00", {parity_err, frame_err}); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (Data7 !== 7'h00) $display("FAIL reset_data7: got %h want 00", Data7); else n_pass++;
    Reset_n = 1'b1;
    idle(5);
  endtask

  task automatic test_8n1;
    int d0;
    d0 = done_cnt;
    drive(0, frame(9'h0A5, 8, -1), 10, -1, -1, 0);
    idle(8);
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL 8n1_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_total++; if (last_data !== 8'hA5) $display("FAIL 8n1_data: got %h want a5", last_data); else n_pass++;
    n_total++; if ({last_perr, last_ferr} !== 2'b00) $display("FAIL 8n1_errs: got %b want 00", {last_perr, last_ferr}); else n_pass++;
    n_total++; if (done_cyc - start_cyc !== 616) $display("FAIL 8n1_latency: got %0d want 616", done_cyc - start_cyc); else n_pass++;
  endtask

  task automatic test_baud0;
    baud_div = 16'd0;
    drive(0, frame(9'h03C, 8, -1), 10, -1, -1, 0);
    idle(8);
    n_total++; if (last_data !== 8'h3C) $display("FAIL baud0_data: got %h want 3c", last_data); else n_pass++;
    n_total++; if (done_cyc - start_cyc !== 157) $display("FAIL baud0_latency: got %0d want 157", done_cyc - start_cyc); else n_pass++;
    baud_div = 16'd3;
  endtask

  task automatic test_parity;
    parity_mode = 2'd1;
    drive(0, frame(9'h003, 8, 1), 11, -1, -1, 0);
    idle(8);
    n_total++; if (last_data !== 8'h03) $display("FAIL even_data: got %h want 03", last_data); else n_pass++;
    n_total++; if (last_perr !== 1'b1) $display("FAIL even_bad: got %b want 1", last_perr); else n_pass++;
    drive(0, frame(9'h003, 8, 0), 11, -1, -1, 0);
    idle(8);
    n_total++; if (last_perr !== 1'b0) $display("FAIL even_good: got %b want 0", last_perr); else n_pass++;
    parity_mode = 2'd2;
    drive(0, frame(9'h003, 8, 1), 11, -1, -1, 0);
    idle(8);
    n_total++; if (last_perr !== 1'b0) $display("FAIL odd_good: got %b want 0", last_perr); else n_pass++;
    drive(0, frame(9'h003, 8, 0), 11, -1, -1, 0);
    idle(8);
    n_total++; if (last_perr !== 1'b1) $display("FAIL odd_bad: got %b want 1", last_perr); else n_pass++;
    parity_mode = 2'd0;
  endtask

  task automatic test_stop2_break;
    logic [31:0] f;
    int d0;
    stop_bits = 1'b1;
    f = frame(9'h05A, 8, -1);
    f[10] = 1'b0;
    drive(0, f, 11, -1, -1, 0);
    idle(8);
    n_total++; if (last_ferr !== 1'b1) $display("FAIL stop2_ferr: got %b want 1", last_ferr); else n_pass++;
    n_total++; if (last_data !== 8'h5A) $display("FAIL stop2_data: got %h want 5a", last_data); else n_pass++;
    d0 = done_cnt;
    drive(0, 32'h0, 20, -1, -1, 0);
    idle(8);
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL break_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_total++; if ({last_data, last_ferr} !== {8'h00, 1'b1}) $display("FAIL break_frame: got %h/%b want 00/1", last_data, last_ferr); else n_pass++;
    idle(300);
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL break_quiet: got %0d want 1", done_cnt - d0); else n_pass++;
    drive(0, frame(9'h081, 8, -1), 11, -1, -1, 0);
    idle(8);
    n_total++; if ({last_data, last_ferr} !== {8'h81, 1'b0}) $display("FAIL after_break: got %h/%b want 81/0", last_data, last_ferr); else n_pass++;
    stop_bits = 1'b0;
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    busy_seen = 1'b0;
    drive(0, 32'hFFFF_FFFF, 10, 0, 3, 0);
    idle(8);
    n_total++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (done_cnt - d0 !== 0) $display("FAIL glitch_no_done: got %0d want 0", done_cnt - d0); else n_pass++;
    drive(0, frame(9'h0FF, 8, -1), 10, 4*64 + 30, 4*64 + 33, 0);
    idle(8);
    n_total++; if (last_data !== 8'hFF) $display("FAIL vote_data: got %h want ff", last_data); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] f;
    int d0;
    d0 = done_cnt;
    f = (frame(9'h011, 8, -1) & 32'h0000_03FF) | (frame(9'h022, 8, -1) << 10);
    drive(0, f, 20, -1, -1, 0);
    idle(8);
    n_total++; if (done_cnt - d0 !== 2) $display("FAIL b2b_count: got %0d want 2", done_cnt - d0); else n_pass++;
    n_total++; if (data_log[d0 % 32] !== 8'h11) $display("FAIL b2b_first: got %h want 11", data_log[d0 % 32]); else n_pass++;
    n_total++; if (data_log[(d0 + 1) % 32] !== 8'h22) $display("FAIL b2b_second: got %h want 22", data_log[(d0 + 1) % 32]); else n_pass++;
  endtask

  task automatic test_width7;
    int d0;
    d0 = done7_cnt;
    drive(1, frame(9'h07F, 7, -1), 9, -1, -1, 0);
    idle(8);
    n_total++; if (done7_cnt - d0 !== 1) $display("FAIL w7_count: got %0d want 1", done7_cnt - d0); else n_pass++;
    n_total++; if (last_data7 !== 7'h7F) $display("FAIL w7_data: got %h want 7f", last_data7); else n_pass++;
    drive(1, frame(9'h02A, 7, -1), 9, -1, -1, 0);
    idle(8);
    n_total++; if (last_data7 !== 7'h2A) $display("FAIL w7_data2: got %h want 2a", last_data7); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    drive(0, frame(9'h096, 8, -1), 10, -1, -1, 5*64 + 32);
    n_total++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else n_pass++;
    uart_rx = 1'b1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    n_total++; if (Data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", Data); else n_pass++;
    n_total++; if ({Rx_Done, parity_err, frame_err, busy} !== 4'b0000) $display("FAIL rst_mid_flags: got %b want 0000", {Rx_Done, parity_err, frame_err, busy}); else n_pass++;
    idle(2);
    Reset_n = 1'b1;
    idle(20);
    n_total++; if (done_cnt - d0 !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", done_cnt - d0); else n_pass++;
    drive(0, frame(9'h0C3, 8, -1), 10, -1, -1, 0);
    idle(8);
    n_total++; if (last_data !== 8'hC3) $display("FAIL rst_mid_next: got %h want c3", last_data); else n_pass++;
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL rst_mid_count: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_baud0();
    test_parity();
    test_stop2_break();
    test_glitch();
    test_back_to_back();
    test_width7();
    test_reset_mid();
    n_total++; if (wide_cnt !== 0) $display("FAIL done_width: got %0d wide pulses want 0", wide_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
